gray_sync_decode: RTL

Receive-side stage for gray-coded counts. It samples a gray-coded bus from an unrelated clock domain through a synchronizer chain and decodes it to binary. It checks that every observed change is a legal single-bit gray step, and reports step direction and illegal-jump errors. It sits directly downstream of the binary-to-gray encoder and consumes its output, typically a FIFO pointer or position counter crossing domains.

---
 rtl/gray_pkg.sv | 25 ++
 rtl/sync_chain.sv | 30 +++
 rtl/gray_sync_decode.sv | 68 ++++++
 3 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared gray/binary helpers for both sides of a gray-coded crossing
package gray_pkg;

  localparam int ERR_CNT_W = 8;
  localparam int GRAY_MAX_W = 32;

  // Operates on a zero-extended value, so any width up to GRAY_MAX_W decodes correctly.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic onehot_or_zero(input logic [GRAY_MAX_W-1:0] v);
    return (v & (v - 1'b1)) == '0;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - plain multi-flop synchronizer for a bus that only ever changes one bit at a time
module sync_chain #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  // Nothing but wires between stages, so each flop gets a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_decode.sv
// rtl/gray_sync_decode.sv - synchronize a gray-coded count, decode it, and flag illegal multi-bit jumps
module gray_sync_decode
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     g_in,
  output logic [WIDTH-1:0]     b_out,
  output logic                 b_valid,
  output logic                 dir,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] g_prev;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] b_next;
  logic             changed;
  logic             legal;
  logic             step_up;

  sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (g_in),
    .q     (g_s)
  );

  always_comb begin
    diff    = g_s ^ g_prev;
    changed = |diff;
    legal   = onehot_or_zero(GRAY_MAX_W'(diff));
    b_next  = WIDTH'(gray2bin(GRAY_MAX_W'(g_s)));
    // Truncation to WIDTH makes the max->0 wrap count as an up step.
    step_up = (b_next == WIDTH'(b_out + 1'b1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_prev   <= '0;
      b_out    <= '0;
      b_valid  <= 1'b0;
      step_err <= 1'b0;
      dir      <= 1'b1;
      err_cnt  <= '0;
    end else begin
      b_valid  <= changed;
      step_err <= changed && !legal;
      if (changed) begin
        g_prev <= g_s;
        b_out  <= b_next;
        if (legal) begin
          dir <= step_up;
        end else if (err_cnt != {ERR_CNT_W{1'b1}}) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule
